// File: rtl/ram_banked_clr.sv
// Banked word RAM with a hardware clear sequencer.
// The address MSBs pick one of 2^BANK_BITS banks and the LSBs pick the word inside it.
// Reads are combinational and writes are synchronous.
// After reset, or when clear is requested, every bank clears the same offset on each
// edge. The whole store is therefore wiped in BANK_DEPTH cycles, not 2^ADDR_BITS.
module ram_banked_clr #(
   parameter int WIDTH = 16,
   parameter int ADDR_BITS = 12,
   parameter int BANK_BITS = 3,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     in,
   input  logic                 load,
   input  logic [ADDR_BITS-1:0] address,
   input  logic                 clear,
   output logic [WIDTH-1:0]     out,
   output logic                 busy,
   output logic                 load_drop
);

   localparam int OFF_BITS = ADDR_BITS - BANK_BITS;
   localparam int NUM_BANKS = 2 ** BANK_BITS;
   localparam int BANK_DEPTH = 2 ** OFF_BITS;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t state;
   state_t stateNext;
   logic [OFF_BITS-1:0] cnt;
   logic [OFF_BITS-1:0] cntNext;
   logic dropNext;
   logic userWrite;
   logic sweepWrite;
   logic [BANK_BITS-1:0] bank;
   logic [OFF_BITS-1:0] offset;
   logic [WIDTH-1:0] bankData [NUM_BANKS];

   assign bank = address[ADDR_BITS-1 -: BANK_BITS];
   assign offset = address[OFF_BITS-1:0];

   // State, sweep counter and the registered dropped-write pulse.
   // Reset only restarts the sweep. It never touches the array itself.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
         cnt <= '0;
         load_drop <= 1'b0;
      end else begin
         state <= stateNext;
         cnt <= cntNext;
         load_drop <= dropNext;
      end
   end

   // Sequencing rules. A clear request wins over a load, and any load that arrives
   // while sweeping or while requesting a clear is reported as dropped.
   always_comb begin
      stateNext = state;
      cntNext = cnt;
      dropNext = 1'b0;
      case (state)
         IDLE: begin
            if (clear) begin
               stateNext = CLEAR;
               cntNext = '0;
               dropNext = load;
            end
         end
         CLEAR: begin
            dropNext = load;
            if (clear) begin
               cntNext = '0;
            end else begin
               cntNext = cnt + 1'b1;
               if (cnt == {OFF_BITS{1'b1}}) begin
                  stateNext = IDLE;
               end
            end
         end
         default: begin
            stateNext = CLEAR;
            cntNext = '0;
         end
      endcase
   end

   // Outputs and write strobes. While busy, the read port shows CLEAR_VALUE
   // so that half-cleared contents are never visible.
   always_comb begin
      busy = (state == CLEAR);
      sweepWrite = (state == CLEAR) && !reset;
      userWrite = (state == IDLE) && !reset && !clear && load;
      out = busy ? CLEAR_VALUE : bankData[bank];
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : gBank
      logic [WIDTH-1:0] store [BANK_DEPTH];

      // One physical bank. The sweep clears offset cnt in every bank at once,
      // and a user write lands only in the bank its address decodes to.
      always_ff @(posedge clk) begin
         if (sweepWrite) begin
            store[cnt] <= CLEAR_VALUE;
         end else if (userWrite && (bank == BANK_BITS'(g))) begin
            store[offset] <= in;
         end
      end

      assign bankData[g] = store[offset];
   end

endmodule

// File: tb/tb_ram_banked_clr.sv
// Self-checking bench for ram_banked_clr.
// It keeps a flat word-array model and tracks the remaining sweep length.
module tb_ram_banked_clr;

   localparam int DEPTH = 4096;
   localparam int BANK_DEPTH = 512;

   logic clk = 1'b0;
   logic reset;
   logic [15:0] in;
   logic load;
   logic [11:0] address;
   logic clear;
   logic [15:0] out;
   logic busy;
   logic load_drop;

   int total = 0;
   int bad = 0;

   logic [15:0] model [0:DEPTH-1];
   logic busyM = 1'b1;
   int remainM = BANK_DEPTH;
   logic dropM = 1'b0;

   ram_banked_clr #(
      .WIDTH(16),
      .ADDR_BITS(12),
      .BANK_BITS(3),
      .CLEAR_VALUE(16'h0000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in(in),
      .load(load),
      .address(address),
      .clear(clear),
      .out(out),
      .busy(busy),
      .load_drop(load_drop)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Safety net in case the DUT never leaves a sweep.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Applies the effect of the upcoming edge to the model, using the current inputs.
   task automatic modelStep();
      if (reset) begin
         busyM = 1'b1;
         remainM = BANK_DEPTH;
         dropM = 1'b0;
      end else if (busyM) begin
         dropM = load;
         if (clear) begin
            remainM = BANK_DEPTH;
         end else begin
            remainM--;
            if (remainM == 0) begin
               busyM = 1'b0;
               for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
            end
         end
      end else if (clear) begin
         busyM = 1'b1;
         remainM = BANK_DEPTH;
         dropM = load;
      end else begin
         dropM = 1'b0;
         if (load) model[address] = in;
      end
   endtask

   function automatic logic [15:0] expOut();
      return busyM ? 16'h0000 : model[address];
   endfunction

   task automatic cycle();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [11:0] a, input logic [15:0] d, input logic ld, input logic clr);
      address = a;
      in = d;
      load = ld;
      clear = clr;
   endtask

   // Counts edges until busy falls, bounded so that the run cannot hang.
   task automatic waitSweep(output int n);
      applyStimulus(12'h000, 16'h0000, 1'b0, 1'b0);
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         cycle();
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      logic dropSeen;
      reset = 1'b1;
      applyStimulus(12'h000, 16'h0000, 1'b0, 1'b0);
      cycle();
      total++;
      if (busy !== 1'b1) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
      total++;
      if (load_drop !== 1'b0) begin bad++; $display("[TB] FAIL reset_drop: got %b expected 0", load_drop); end
      total++;
      if (out !== 16'h0000) begin bad++; $display("[TB] FAIL reset_out: got %h expected 0000", out); end
      cycle();
      reset = 1'b0;
      n = 0;
      dropSeen = 1'b0;
      while (busy === 1'b1 && n < 1000) begin
         cycle();
         n++;
         if (load_drop !== 1'b0) dropSeen = 1'b1;
      end
      total++;
      if (n != BANK_DEPTH) begin bad++; $display("[TB] FAIL reset_sweep_len: got %0d expected %0d", n, BANK_DEPTH); end
      total++;
      if (dropSeen !== 1'b0) begin bad++; $display("[TB] FAIL reset_sweep_drop: got %b expected 0", dropSeen); end
      foreach (model[i]) begin
         if (i == 0 || i == 12'h7FF || i == 12'hFFF) begin
            address = 12'(i);
            #1;
            total++;
            if (out !== 16'h0000) begin bad++; $display("[TB] FAIL reset_read %h: got %h expected 0000", address, out); end
         end
      end
   endtask

   task automatic test_write_isolation();
      applyStimulus(12'hA05, 16'hBEEF, 1'b1, 1'b0);
      #1;
      total++;
      if (out !== 16'h0000) begin bad++; $display("[TB] FAIL write_old_value: got %h expected 0000", out); end
      cycle();
      load = 1'b0;
      #1;
      total++;
      if (out !== 16'hBEEF) begin bad++; $display("[TB] FAIL write_new_value: got %h expected beef", out); end
      address = 12'h005;
      #1;
      total++;
      if (out !== 16'h0000) begin bad++; $display("[TB] FAIL isolation_005: got %h expected 0000", out); end
      address = 12'h205;
      #1;
      total++;
      if (out !== 16'h0000) begin bad++; $display("[TB] FAIL isolation_205: got %h expected 0000", out); end
   endtask

   task automatic test_boundary();
      applyStimulus(12'h000, 16'h1234, 1'b1, 1'b0);
      cycle();
      applyStimulus(12'hFFF, 16'hFFFF, 1'b1, 1'b0);
      cycle();
      applyStimulus(12'h000, 16'h0000, 1'b0, 1'b0);
      #1;
      total++;
      if (out !== 16'h1234) begin bad++; $display("[TB] FAIL first_word: got %h expected 1234", out); end
      address = 12'hFFF;
      #1;
      total++;
      if (out !== 16'hFFFF) begin bad++; $display("[TB] FAIL last_word: got %h expected ffff", out); end
      address = 12'h001;
      #1;
      total++;
      if (out !== 16'h0000) begin bad++; $display("[TB] FAIL neighbour_001: got %h expected 0000", out); end
      address = 12'hFFE;
      #1;
      total++;
      if (out !== 16'h0000) begin bad++; $display("[TB] FAIL neighbour_ffe: got %h expected 0000", out); end
   endtask

   task automatic test_load_during_sweep();
      int n;
      applyStimulus(12'h000, 16'h0000, 1'b0, 1'b0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      repeat (5) cycle();
      applyStimulus(12'h010, 16'hAAAA, 1'b1, 1'b0);
      #1;
      total++;
      if (out !== 16'h0000) begin bad++; $display("[TB] FAIL sweep_out: got %h expected 0000", out); end
      cycle();
      load = 1'b0;
      total++;
      if (load_drop !== 1'b1) begin bad++; $display("[TB] FAIL sweep_drop_pulse: got %b expected 1", load_drop); end
      cycle();
      total++;
      if (load_drop !== 1'b0) begin bad++; $display("[TB] FAIL sweep_drop_end: got %b expected 0", load_drop); end
      waitSweep(n);
      total++;
      if (n != BANK_DEPTH - 7) begin bad++; $display("[TB] FAIL sweep_remaining: got %0d expected %0d", n, BANK_DEPTH - 7); end
      address = 12'h010;
      #1;
      total++;
      if (out !== 16'h0000) begin bad++; $display("[TB] FAIL dropped_word: got %h expected 0000", out); end
   endtask

   task automatic test_clear_with_load();
      int n;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(12'h300 + 12'(i), 16'h5555, 1'b1, 1'b0);
         cycle();
      end
      applyStimulus(12'h30A, 16'h0000, 1'b0, 1'b0);
      #1;
      total++;
      if (out !== 16'h5555) begin bad++; $display("[TB] FAIL fill_readback: got %h expected 5555", out); end
      applyStimulus(12'h300, 16'h1111, 1'b1, 1'b1);
      cycle();
      applyStimulus(12'h300, 16'h0000, 1'b0, 1'b0);
      total++;
      if (load_drop !== 1'b1) begin bad++; $display("[TB] FAIL clear_drop: got %b expected 1", load_drop); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("[TB] FAIL clear_busy: got %b expected 1", busy); end
      waitSweep(n);
      total++;
      if (n != BANK_DEPTH) begin bad++; $display("[TB] FAIL clear_sweep_len: got %0d expected %0d", n, BANK_DEPTH); end
      for (int i = 0; i < 16; i++) begin
         address = 12'h300 + 12'(i);
         #1;
         total++;
         if (out !== 16'h0000) begin bad++; $display("[TB] FAIL region_cleared %h: got %h expected 0000", address, out); end
      end
   endtask

   task automatic test_mid_sweep_restart(input logic useReset);
      int n;
      applyStimulus(12'h7FF, 16'hCAFE, 1'b1, 1'b0);
      cycle();
      applyStimulus(12'h000, 16'h0000, 1'b0, 1'b1);
      cycle();
      clear = 1'b0;
      repeat (200) cycle();
      if (useReset) reset = 1'b1;
      else clear = 1'b1;
      cycle();
      reset = 1'b0;
      clear = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("[TB] FAIL restart_busy(reset=%b): got %b expected 1", useReset, busy); end
      waitSweep(n);
      total++;
      if (n != BANK_DEPTH) begin bad++; $display("[TB] FAIL restart_len(reset=%b): got %0d expected %0d", useReset, n, BANK_DEPTH); end
      address = 12'h7FF;
      #1;
      total++;
      if (out !== 16'h0000) begin bad++; $display("[TB] FAIL restart_word(reset=%b): got %h expected 0000", useReset, out); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         applyStimulus(12'($urandom) & 12'hE07, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         #1;
         total++;
         if (out !== expOut()) begin bad++; $display("[TB] FAIL rand_out %h: got %h expected %h", address, out, expOut()); end
         cycle();
         total++;
         if (load_drop !== dropM || busy !== busyM) begin
            bad++;
            $display("[TB] FAIL rand_flags: got drop=%b busy=%b expected drop=%b busy=%b", load_drop, busy, dropM, busyM);
         end
      end
      applyStimulus(12'h000, 16'h0000, 1'b0, 1'b0);
   endtask

   // Runs every scenario in order and reports the summary.
   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
      reset = 1'b1;
      applyStimulus(12'h000, 16'h0000, 1'b0, 1'b0);
      test_reset();
      test_write_isolation();
      test_boundary();
      test_random();
      test_load_during_sweep();
      test_clear_with_load();
      test_mid_sweep_restart(1'b1);
      test_mid_sweep_restart(1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_banked_clr.md
Name: ram_banked_clr

Overview:
Parametrised banked word RAM, the generalised successor of the fixed 4K x 16 bank-decoded RAM.
- Storage is split into 2^BANK_BITS banks; address MSBs select the bank, LSBs select the offset inside it.
- Read is combinational; writes are synchronous.
- New versus the fixed part: hardware clear sequencer runs after reset and on request, writing CLEAR_VALUE to all banks in parallel, with a busy flag and dropped-write reporting.
- Sits in the data-memory path, usable as a drop-in for RAM4K/RAM16K-sized stores.

Parameters:
WIDTH, 16, data word width in bits
ADDR_BITS, 12, total address width; depth = 2^ADDR_BITS words
BANK_BITS, 3, bank select width (address[ADDR_BITS-1 -: BANK_BITS]); requires 1 <= BANK_BITS < ADDR_BITS
CLEAR_VALUE, 0, word written by the clear sweep

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high; starts the clear sweep
in  input  WIDTH  write data
load  input  1  write enable
address  input  ADDR_BITS  word address for read and write
clear  input  1  synchronous request to re-run the clear sweep
out  output  WIDTH  read data
busy  output  1  high while the clear sweep is active
load_drop  output  1  registered one-cycle pulse: a load was ignored

Behaviour:
- Derived values: BANK_DEPTH = 2^(ADDR_BITS-BANK_BITS).
  - bank = address[ADDR_BITS-1 -: BANK_BITS]
  - offset = address[ADDR_BITS-BANK_BITS-1:0]
- States: IDLE, CLEAR. Sweep counter cnt is ADDR_BITS-BANK_BITS bits wide.
- Reset edge (reset=1):
  - state<=CLEAR, cnt<=0, load_drop<=0.
  - No array write occurs on this edge.
  - busy=1 from the cycle after the first reset edge.
  - Holding reset keeps cnt at 0.
- CLEAR, reset=0 edge:
  - Write CLEAR_VALUE at offset cnt in every bank simultaneously, then cnt<=cnt+1.
  - If cnt==BANK_DEPTH-1: state<=IDLE.
  - The sweep therefore takes exactly BANK_DEPTH edges after reset release (512 by default). busy is combinational from state (busy = state==CLEAR).
- IDLE, reset=0 edge:
  - If clear=1: state<=CLEAR, cnt<=0. clear has priority over load, so that cycle's load is ignored and load_drop<=1.
  - Else if load=1: mem[bank][offset]<=in.
- clear=1 while already in CLEAR restarts the sweep (cnt<=0).
- load=1 during CLEAR (or in the clear-request cycle) is not written; load_drop<=1 on that edge. Otherwise load_drop<=0.
- Read path:
  - While busy=0: out = mem[bank][offset], purely combinational.
  - A write to the addressed word shows the new value only after the edge; same-cycle out shows the old value.
  - While busy=1: out = CLEAR_VALUE, so no stale data is visible.
- Reset values: busy=1 (state CLEAR), load_drop=0, out=CLEAR_VALUE.
  - Array contents are undefined until the sweep completes.
- Reset mid-sweep: the sweep restarts from cnt=0; already-cleared words stay cleared.
- Address wrap: none. Every ADDR_BITS value maps to exactly one word. Bank decode must be exact; a write touches exactly one bank.
- Implementation: banks may be separate arrays or one array indexed {bank,offset}. The sweep must complete in BANK_DEPTH cycles, not 2^ADDR_BITS.

Test Plan:
- Reset high 2 cycles, then low -> busy high for exactly 512 edges after release, then 0. Read of 12'h000, 12'h7FF, 12'hFFF returns 16'h0000; load_drop stays 0.
- After sweep, load=1, in=16'hBEEF, address=12'hA05 -> out at 12'hA05 reads 16'hBEEF the cycle after the edge (old 0 in the same cycle). 12'h005 and 12'h205 still read 0, confirming bank isolation.
- Write 16'h1234 to 12'h000 and 16'hFFFF to 12'hFFF (first/last word, first/last bank) -> both read back exactly; neighbours 12'h001 and 12'hFFE read 0.
- During sweep, load=1 to 12'h010 with 16'hAAAA -> load_drop pulses 1 for one cycle and out=0 while busy. After busy falls, 12'h010 reads 16'h0000.
- Fill 12'h300..12'h30F with 16'h5555, pulse clear with simultaneous load -> load ignored, load_drop=1, busy for 512 edges. Region reads 0 afterwards.
- Mid-sweep (cnt=200) assert reset or clear for one cycle -> sweep restarts; busy stays high for 512 further edges after release; all words read 0.
